clk_tick_monitor: RTL

//  Consumes a slow clock (typically a divided clock from the clock divider) in
//  the fast system clock domain. Synchronises it and emits one-cycle rise/fall

---
 rtl/clk_tick_monitor.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/clk_tick_monitor.sv
// clk_tick_monitor: synchronises a slow clock/strobe into the system clock
// domain, emits one-cycle rise/fall ticks, counts rising edges, measures the
// rising-edge period in system cycles and flags a stalled input.
module clk_tick_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024,
    parameter int CNT_W       = 16,
    localparam int PW         = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             clr,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] count,
    output logic [PW-1:0]    period,
    output logic             period_valid,
    output logic             stall
);

    localparam logic [PW-1:0] GAP_MAX  = PW'(TIMEOUT);
    localparam logic [PW-1:0] GAP_LAST = PW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        WAIT_EDGE,
        MEASURE,
        STALLED
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] s;
    logic                   prev;
    logic                   s_last;
    logic                   d_r;
    logic                   d_f;

    logic [PW-1:0]          gap, gap_nxt;
    logic [CNT_W-1:0]       count_nxt;
    logic [PW-1:0]          period_nxt;
    logic                   period_valid_nxt;
    logic                   stall_nxt;
    logic                   gap_hits_max;

    assign s_last = s[SYNC_STAGES-1];
    assign d_r    = s_last & ~prev;
    assign d_f    = ~s_last & prev;

    // The gap counter is about to saturate on this edge (no rising edge restarts it).
    assign gap_hits_max = ~d_r && (gap == GAP_LAST);

    // Synchroniser chain, edge history and registered tick outputs; untouched by clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s     <= '0;
            prev  <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s     <= {s[SYNC_STAGES-2:0], in};
            prev  <= s_last;
            level <= s_last;
            rise  <= d_r;
            fall  <= d_f;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_EDGE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; clr overrides any edge seen on the same cycle.
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = WAIT_EDGE;
        end else begin
            unique case (state)
                WAIT_EDGE: begin
                    if (d_r)               state_nxt = MEASURE;
                    else if (gap_hits_max) state_nxt = STALLED;
                end
                MEASURE: begin
                    if (gap_hits_max)      state_nxt = STALLED;
                end
                STALLED: begin
                    if (d_r)               state_nxt = MEASURE;
                end
                default:                   state_nxt = WAIT_EDGE;
            endcase
        end
    end

    // Next values of the registered measurement outputs, gap and edge count.
    always_comb begin
        gap_nxt          = gap;
        count_nxt        = count;
        period_nxt       = period;
        period_valid_nxt = period_valid;
        stall_nxt        = stall;
        if (clr) begin
            gap_nxt          = '0;
            count_nxt        = '0;
            period_nxt       = '0;
            period_valid_nxt = 1'b0;
            stall_nxt        = 1'b0;
        end else begin
            if (d_r) begin
                gap_nxt   = PW'(1);
                count_nxt = count + CNT_W'(1);
            end else if (gap < GAP_MAX) begin
                gap_nxt = gap + PW'(1);
            end
            unique case (state)
                WAIT_EDGE: begin
                    if (gap_hits_max) stall_nxt = 1'b1;
                end
                MEASURE: begin
                    if (d_r) begin
                        period_nxt       = gap;
                        period_valid_nxt = 1'b1;
                    end else if (gap_hits_max) begin
                        stall_nxt        = 1'b1;
                        period_valid_nxt = 1'b0;
                    end
                end
                STALLED: begin
                    // The overflowed gap is not a measurement; validity
                    // returns only after the next full period.
                    if (d_r) stall_nxt = 1'b0;
                end
                default: begin
                    stall_nxt = 1'b0;
                end
            endcase
        end
    end

    // Measurement, gap and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap          <= '0;
            count        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            stall        <= 1'b0;
        end else begin
            gap          <= gap_nxt;
            count        <= count_nxt;
            period       <= period_nxt;
            period_valid <= period_valid_nxt;
            stall        <= stall_nxt;
        end
    end

endmodule
